// File: rtl/i2s_xmit.sv
// I2S transmitter: divides mck into bck/lrck and shifts buffered stereo pairs out MSB first.
// One pair is held in a pending buffer while the active pair is serialized.
module i2s_xmit #(
  parameter int WIDTH   = 24,
  parameter int SLOT    = 32,
  parameter int BCK_DIV = 4
) (
  input  logic                    mck,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_left,
  input  logic signed [WIDTH-1:0] in_right,
  output logic                    bck,
  output logic                    lrck,
  output logic                    sdata,
  output logic                    underrun
);

  localparam int FRAME = 2 * SLOT;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = $clog2(BCK_DIV);

  logic [DW-1:0]           div_cnt_q, div_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    bck_q, bck_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;
  logic                    pend_full_q, pend_full_d;
  logic signed [WIDTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic signed [WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                    bit_edge;

  // k is the bit index within the frame of the bit being presented (b-1 mod frame).
  function automatic logic sdata_bit(input logic [BW-1:0] k,
                                     input logic signed [WIDTH-1:0] l,
                                     input logic signed [WIDTH-1:0] r);
    logic [BW-1:0]    j;
    logic [WIDTH-1:0] sh;
    if (k >= BW'(SLOT)) begin
      j  = k - BW'(SLOT);
      sh = r;
    end else begin
      j  = k;
      sh = l;
    end
    sh = sh << j;
    return (j < BW'(WIDTH)) ? sh[WIDTH-1] : 1'b0;
  endfunction

  always_comb begin
    bit_edge    = (div_cnt_q == DW'(BCK_DIV - 1));
    div_cnt_d   = bit_edge ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    bck_d       = bck_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    underrun_d  = 1'b0;
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;

    if (div_cnt_d == DW'(BCK_DIV / 2)) bck_d = 1'b1;
    if (bit_edge) bck_d = 1'b0;

    if (bit_edge) begin
      bit_cnt_d = (bit_cnt_q == BW'(FRAME - 1)) ? '0 : bit_cnt_q + 1'b1;
      // Frame load as bit_cnt leaves 0; the new left MSB goes out on this same edge.
      if (bit_cnt_q == '0) begin
        if (pend_full_q) begin
          act_l_d     = pend_l_q;
          act_r_d     = pend_r_q;
          pend_full_d = 1'b0;
        end else begin
          act_l_d    = '0;
          act_r_d    = '0;
          underrun_d = 1'b1;
        end
      end
      lrck_d  = (bit_cnt_d >= BW'(SLOT));
      sdata_d = sdata_bit(bit_cnt_q, act_l_d, act_r_d);
    end

    // Transfer is gated by the registered ready, so it never collides with a full buffer.
    if (in_valid && !pend_full_q) begin
      pend_l_d    = in_left;
      pend_r_d    = in_right;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge mck) begin
    if (rst) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
      pend_full_q <= 1'b0;
      act_l_q     <= '0;
      act_r_q     <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bck_q       <= bck_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
      pend_full_q <= pend_full_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
    end
  end

  always_ff @(posedge mck) begin
    pend_l_q <= pend_l_d;
    pend_r_q <= pend_r_d;
  end

  assign in_ready = !pend_full_q;
  assign bck      = bck_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_xmit.sv
// Directed bench for i2s_xmit: 24/32/4 instance for timing, framing and handshake,
// plus a 32/32/4 instance for the full-width slot case.
module tb_i2s_xmit;

  localparam int W  = 24;
  localparam int S  = 32;
  localparam int D  = 4;
  localparam int FR = 2 * S;
  localparam int FP = D * FR;

  logic                mck = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_left = '0;
  logic signed [W-1:0] in_right = '0;
  logic                bck, lrck, sdata, underrun;

  logic                rst32 = 1'b1;
  logic                v32 = 1'b0;
  logic                rdy32;
  logic signed [31:0]  l32 = '0;
  logic signed [31:0]  r32 = '0;
  logic                bck32, lr32, sd32, un32;

  i2s_xmit #(.WIDTH(W), .SLOT(S), .BCK_DIV(D)) u_dut (
    .mck(mck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right),
    .bck(bck), .lrck(lrck), .sdata(sdata), .underrun(underrun)
  );

  i2s_xmit #(.WIDTH(32), .SLOT(32), .BCK_DIV(4)) u_dut32 (
    .mck(mck), .rst(rst32), .in_valid(v32), .in_ready(rdy32),
    .in_left(l32), .in_right(r32),
    .bck(bck32), .lrck(lr32), .sdata(sd32), .underrun(un32)
  );

  always #5 mck = ~mck;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int feed_start = 0;
  int nacc = 0;
  int first_rise = -1;
  int acc_cyc[8];
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_r[$];
  logic [W-1:0] fr_l[8], fr_r[8], cap_l[8], cap_r[8];
  logic         fr_u[8], pad[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected sdata after edge c (edges counted from the reset edge = 0); frame f loads at c = D + f*FP.
  function automatic logic exp_sd(input int c);
    int f, b, k, j;
    logic [W-1:0] src;
    if (c < D) return 1'b0;
    f = (c - D) / FP;
    if (f > 7) return 1'b0;
    b = (c / D) % FR;
    k = (b + FR - 1) % FR;
    j = k % S;
    src = (k >= S) ? fr_r[f] : fr_l[f];
    if (j >= W) return 1'b0;
    src = src << j;
    return src[W-1];
  endfunction

  task automatic rst_dut();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge mck); #1;
    chk("rst_bck", 32'(bck), 0);
    chk("rst_lrck", 32'(lrck), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    cyc = 0;
    nacc = 0;
    first_rise = -1;
    feed_start = 0;
    q_l.delete();
    q_r.delete();
    for (int i = 0; i < 8; i++) begin
      fr_l[i] = '0; fr_r[i] = '0; fr_u[i] = 1'b1;
      cap_l[i] = '0; cap_r[i] = '0; pad[i] = 1'b0;
      acc_cyc[i] = -1;
    end
  endtask

  task automatic run(input int n, input string tag);
    int bad_bck, bad_lr, bad_sd, bad_un, f, b;
    logic rdy_pre, e_bck, e_lr, e_un;
    bad_bck = 0; bad_lr = 0; bad_sd = 0; bad_un = 0;
    for (int i = 0; i < n; i++) begin
      if (q_l.size() > 0 && cyc >= feed_start) begin
        in_valid = 1'b1; in_left = q_l[0]; in_right = q_r[0];
      end else begin
        in_valid = 1'b0;
      end
      rdy_pre = in_ready;
      @(posedge mck); #1;
      cyc++;
      if (in_valid && rdy_pre) begin
        if (nacc < 8) acc_cyc[nacc] = cyc;
        nacc++;
        void'(q_l.pop_front());
        void'(q_r.pop_front());
      end
      b     = (cyc / D) % FR;
      e_bck = ((cyc % D) >= D / 2);
      e_lr  = (b >= S);
      f     = (cyc >= D) ? (cyc - D) / FP : -1;
      e_un  = (cyc >= D) && ((cyc - D) % FP == 0) && (f < 8) && fr_u[f];
      if (bck !== e_bck) bad_bck++;
      if (lrck !== e_lr) bad_lr++;
      if (sdata !== exp_sd(cyc)) bad_sd++;
      if (underrun !== e_un) bad_un++;
      if (lrck === 1'b1 && first_rise < 0) first_rise = cyc;
      if (f >= 0 && f < 8 && (cyc % D) == 0) begin
        if (b >= 1 && b <= W) cap_l[f] = {cap_l[f][W-2:0], sdata};
        else if (b >= S + 1 && b <= S + W) cap_r[f] = {cap_r[f][W-2:0], sdata};
        else pad[f] = pad[f] | sdata;
      end
    end
    chk({tag, "_bck"}, bad_bck, 0);
    chk({tag, "_lrck"}, bad_lr, 0);
    chk({tag, "_sdata"}, bad_sd, 0);
    chk({tag, "_underrun"}, bad_un, 0);
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    q_l.push_back(l);
    q_r.push_back(r);
  endtask

  int ones_b0, ones_after, ones_left, und, und_at, rdy_at1;

  initial begin
    // Idle: zero frames with an underrun at every load; lrck rises 128 edges after the reset edge.
    rst_dut();
    run(300, "idle");
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_lrck_rise", first_rise, 128);

    // Single pair written before the first load.
    rst_dut();
    push(24'hA5F00F, 24'h123456);
    fr_l[0] = 24'hA5F00F; fr_r[0] = 24'h123456; fr_u[0] = 1'b0;
    run(1, "t2a");
    chk("t2_ready_low", 32'(in_ready), 0);
    run(269, "t2");
    chk("t2_left", 32'(cap_l[0]), 32'h00A5F00F);
    chk("t2_right", 32'(cap_r[0]), 32'h00123456);
    chk("t2_pad", 32'(pad[0]), 0);
    chk("t2_acc", acc_cyc[0], 1);

    // Three pairs with in_valid held.
    rst_dut();
    push(24'h800001, 24'h7FFFFE);
    push(24'h0F0F0F, 24'hF0F0F0);
    push(24'h13579B, 24'h2468AC);
    fr_l[0] = 24'h800001; fr_r[0] = 24'h7FFFFE; fr_u[0] = 1'b0;
    fr_l[1] = 24'h0F0F0F; fr_r[1] = 24'hF0F0F0; fr_u[1] = 1'b0;
    fr_l[2] = 24'h13579B; fr_r[2] = 24'h2468AC; fr_u[2] = 1'b0;
    run(790, "t3");
    chk("t3_nacc", nacc, 3);
    chk("t3_acc0", acc_cyc[0], 1);
    chk("t3_acc1", acc_cyc[1], 5);
    chk("t3_acc2", acc_cyc[2], 261);
    chk("t3_l0", 32'(cap_l[0]), 32'h00800001);
    chk("t3_r1", 32'(cap_r[1]), 32'h00F0F0F0);
    chk("t3_l2", 32'(cap_l[2]), 32'h0013579B);
    chk("t3_r2", 32'(cap_r[2]), 32'h002468AC);

    // Write landing exactly on the load edge: zero frame now, pair in the next frame.
    rst_dut();
    feed_start = 3;
    push(24'h5A5A5A, 24'hC3C3C3);
    fr_l[1] = 24'h5A5A5A; fr_r[1] = 24'hC3C3C3; fr_u[1] = 1'b0;
    run(530, "t5");
    chk("t5_acc", acc_cyc[0], 4);
    chk("t5_zero_l", 32'(cap_l[0]), 0);
    chk("t5_zero_pad", 32'(pad[0]), 0);
    chk("t5_l1", 32'(cap_l[1]), 32'h005A5A5A);
    chk("t5_r1", 32'(cap_r[1]), 32'h00C3C3C3);

    // Reset in the right slot (b=40) with a pair pending: the pair is dropped.
    rst_dut();
    push(24'h111111, 24'h222222);
    push(24'h333333, 24'h444444);
    fr_l[0] = 24'h111111; fr_r[0] = 24'h222222; fr_u[0] = 1'b0;
    run(161, "t6pre");
    chk("t6_pending_full", 32'(in_ready), 0);
    rst_dut();
    run(270, "t6post");
    chk("t6_lrck_rise", first_rise, 128);
    chk("t6_dropped_l", 32'(cap_l[0]), 0);
    chk("t6_dropped_r", 32'(cap_r[0]), 0);

    // Full-width slot: the right LSB occupies b=0 of the next frame.
    @(posedge mck); #1;
    chk("t4_rst_ready", 32'(rdy32), 1);
    chk("t4_rst_sdata", 32'(sd32), 0);
    rst32 = 1'b0;
    v32 = 1'b1; l32 = 32'h0; r32 = 32'h00000001;
    ones_b0 = 0; ones_after = 0; ones_left = 0; und = 0; und_at = -1; rdy_at1 = -1;
    for (int i = 1; i < 520; i++) begin
      @(posedge mck); #1;
      if (i == 1) begin
        v32 = 1'b0;
        rdy_at1 = 32'(rdy32);
      end
      if (i >= 4 && i < 132 && sd32) ones_left++;
      if (i >= 256 && i < 260 && sd32) ones_b0++;
      if (i >= 260 && sd32) ones_after++;
      if (i <= 515 && un32) begin
        und++;
        und_at = i;
      end
    end
    chk("t4_ready_low", rdy_at1, 0);
    chk("t4_left_zero", ones_left, 0);
    chk("t4_b0_lsb", ones_b0, 4);
    chk("t4_und_cnt", und, 1);
    chk("t4_und_at", und_at, 260);
    chk("t4_zero_frame", ones_after, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
